// File: rtl/wb_xbar_rr.sv
// Shared-bus Wishbone interconnect: round-robin master arbitration, mask/base
// slave decode, internal error responder for unmapped addresses and a bus watchdog.
module wb_xbar_rr #(
  parameter int                         NUM_MASTERS = 2,
  parameter int                         NUM_SLAVES  = 4,
  parameter logic [32*NUM_SLAVES-1:0]   SLAVE_ADDR  = {NUM_SLAVES{32'h0000_0000}},
  parameter logic [32*NUM_SLAVES-1:0]   SLAVE_MASK  = {NUM_SLAVES{32'hF000_0000}},
  parameter int                         TIMEOUT     = 255
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [32*NUM_MASTERS-1:0]  m_adr_i,
  input  logic [32*NUM_MASTERS-1:0]  m_dat_i,
  input  logic [4*NUM_MASTERS-1:0]   m_sel_i,
  input  logic [NUM_MASTERS-1:0]     m_we_i,
  input  logic [NUM_MASTERS-1:0]     m_cyc_i,
  input  logic [NUM_MASTERS-1:0]     m_stb_i,
  output logic [31:0]                m_dat_o,
  output logic [NUM_MASTERS-1:0]     m_ack_o,
  output logic [NUM_MASTERS-1:0]     m_err_o,
  output logic [NUM_MASTERS-1:0]     m_rty_o,
  output logic [31:0]                s_adr_o,
  output logic [31:0]                s_dat_o,
  output logic [3:0]                 s_sel_o,
  output logic                       s_we_o,
  output logic [NUM_SLAVES-1:0]      s_cyc_o,
  output logic [NUM_SLAVES-1:0]      s_stb_o,
  input  logic [32*NUM_SLAVES-1:0]   s_dat_i,
  input  logic [NUM_SLAVES-1:0]      s_ack_i,
  input  logic [NUM_SLAVES-1:0]      s_err_i,
  input  logic [NUM_SLAVES-1:0]      s_rty_i
);

  localparam int NM = NUM_MASTERS;
  localparam int NS = NUM_SLAVES;
  localparam int OW = (NM > 1) ? $clog2(NM) : 1;
  localparam int SW = (NS > 1) ? $clog2(NS) : 1;
  localparam bit         WD_EN   = (TIMEOUT != 0);
  // Timeout fires during the TIMEOUT-th cycle of a strobe, i.e. when the count equals TIMEOUT-1.
  localparam logic [7:0] WD_LAST = (TIMEOUT > 0) ? 8'(TIMEOUT - 1) : 8'd0;

  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic [OW-1:0]   last_q, last_d;
  logic [7:0]      wd_q, wd_d;
  logic            uerr_q, uerr_d;

  logic [31:0]     own_adr_s, own_dat_s;
  logic [3:0]      own_sel_s;
  logic            own_we_s, own_cyc_s, own_stb_s;
  logic            busy_s, own_act_s, strobe_s, timeout_s, term_s;
  logic [SW-1:0]   sel_idx_s;
  logic            mapped_s;
  logic            sl_ack_s, sl_err_s, sl_rty_s;
  logic [31:0]     sl_dat_s;
  logic [OW-1:0]   grant_s;
  logic            found_s;
  int              cand_s;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      last_q  <= OW'(NM - 1);
      wd_q    <= 8'd0;
      uerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      wd_q    <= wd_d;
      uerr_q  <= uerr_d;
    end
  end

  always_comb begin
    own_adr_s = 32'h0000_0000;
    own_dat_s = 32'h0000_0000;
    own_sel_s = 4'h0;
    own_we_s  = 1'b0;
    own_cyc_s = 1'b0;
    own_stb_s = 1'b0;
    for (int i = 0; i < NM; i++) begin
      own_adr_s = (owner_q == OW'(i)) ? m_adr_i[32*i +: 32] : own_adr_s;
      own_dat_s = (owner_q == OW'(i)) ? m_dat_i[32*i +: 32] : own_dat_s;
      own_sel_s = (owner_q == OW'(i)) ? m_sel_i[4*i +: 4]   : own_sel_s;
      own_we_s  = (owner_q == OW'(i)) ? m_we_i[i]           : own_we_s;
      own_cyc_s = (owner_q == OW'(i)) ? m_cyc_i[i]          : own_cyc_s;
      own_stb_s = (owner_q == OW'(i)) ? m_stb_i[i]          : own_stb_s;
    end
  end

  // Descending scan so the lowest-numbered matching slave is the one left selected.
  always_comb begin
    sel_idx_s = '0;
    mapped_s  = 1'b0;
    for (int k = NS - 1; k >= 0; k--) begin
      if ((own_adr_s & SLAVE_MASK[32*k +: 32]) == SLAVE_ADDR[32*k +: 32]) begin
        sel_idx_s = SW'(k);
        mapped_s  = 1'b1;
      end else begin
        sel_idx_s = sel_idx_s;
      end
    end
    sl_ack_s = 1'b0;
    sl_err_s = 1'b0;
    sl_rty_s = 1'b0;
    sl_dat_s = 32'h0000_0000;
    for (int k = 0; k < NS; k++) begin
      sl_ack_s = (sel_idx_s == SW'(k)) ? s_ack_i[k]          : sl_ack_s;
      sl_err_s = (sel_idx_s == SW'(k)) ? s_err_i[k]          : sl_err_s;
      sl_rty_s = (sel_idx_s == SW'(k)) ? s_rty_i[k]          : sl_rty_s;
      sl_dat_s = (sel_idx_s == SW'(k)) ? s_dat_i[32*k +: 32] : sl_dat_s;
    end
  end

  // Round-robin search starting just after the last granted master.
  always_comb begin
    grant_s = last_q;
    found_s = 1'b0;
    cand_s  = 0;
    for (int i = 1; i <= NM; i++) begin
      cand_s = (int'(last_q) + i) % NM;
      if (!found_s && m_cyc_i[cand_s]) begin
        grant_s = OW'(cand_s);
        found_s = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  always_comb begin
    busy_s    = (state_q == ST_BUSY);
    own_act_s = busy_s & own_cyc_s;
    strobe_s  = own_act_s & own_stb_s;
    timeout_s = WD_EN & strobe_s & (wd_q == WD_LAST);
    term_s    = (mapped_s & (sl_ack_s | sl_err_s | sl_rty_s)) | uerr_q;
    wd_d      = (WD_EN & strobe_s & ~term_s & ~timeout_s) ? (wd_q + 8'd1) : 8'd0;
    uerr_d    = strobe_s & ~mapped_s & ~uerr_q;
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (|m_cyc_i) begin
          state_d = ST_BUSY;
          owner_d = grant_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (!own_cyc_s) begin
          state_d = ST_IDLE;
          last_d  = owner_q;
        end else begin
          state_d = ST_BUSY;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A watchdog timeout masks the slave strobe and overrides any slave ack/rty that cycle.
  always_comb begin
    s_adr_o = busy_s ? own_adr_s : 32'h0000_0000;
    s_dat_o = busy_s ? own_dat_s : 32'h0000_0000;
    s_sel_o = busy_s ? own_sel_s : 4'h0;
    s_we_o  = busy_s & own_we_s;
    m_dat_o = (busy_s & mapped_s) ? sl_dat_s : 32'h0000_0000;
    s_cyc_o = '0;
    s_stb_o = '0;
    for (int k = 0; k < NS; k++) begin
      s_cyc_o[k] = own_act_s & mapped_s & (sel_idx_s == SW'(k)) & ~timeout_s;
      s_stb_o[k] = s_cyc_o[k] & own_stb_s;
    end
    m_ack_o = '0;
    m_err_o = '0;
    m_rty_o = '0;
    for (int i = 0; i < NM; i++) begin
      m_ack_o[i] = own_act_s & (owner_q == OW'(i)) & mapped_s & sl_ack_s & ~timeout_s;
      m_rty_o[i] = own_act_s & (owner_q == OW'(i)) & mapped_s & sl_rty_s & ~timeout_s;
      m_err_o[i] = own_act_s & (owner_q == OW'(i)) &
                   ((mapped_s & sl_err_s) | uerr_q | timeout_s);
    end
  end

endmodule

// File: tb/tb_wb_xbar_rr.sv
// Directed bench for wb_xbar_rr: decode, round-robin, atomic hold, unmapped
// error, watchdog (enabled and disabled) and mid-cycle reset.
module tb_wb_xbar_rr;

  localparam int NM = 2;
  localparam int NS = 4;
  localparam logic [127:0] ADDRS = {32'h4000_0000, 32'h6000_0000, 32'h5000_0000, 32'h4000_0000};
  localparam logic [127:0] MASKS = {32'hFF00_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000};

  logic          clk = 1'b0;
  logic          rst;
  logic [63:0]   m_adr, m_dat;
  logic [7:0]    m_sel;
  logic [1:0]    m_we, m_cyc, m_stb;
  logic [127:0]  s_dat;
  logic [3:0]    s_ack, s_err, s_rty;

  logic [31:0]   a_m_dat, a_s_adr, a_s_dat, b_m_dat, b_s_adr, b_s_dat;
  logic [1:0]    a_m_ack, a_m_err, a_m_rty, b_m_ack, b_m_err, b_m_rty;
  logic [3:0]    a_s_sel, a_s_cyc, a_s_stb, b_s_sel, b_s_cyc, b_s_stb;
  logic          a_s_we, b_s_we;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wb_xbar_rr #(.NUM_MASTERS(NM), .NUM_SLAVES(NS), .SLAVE_ADDR(ADDRS),
               .SLAVE_MASK(MASKS), .TIMEOUT(8)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel), .m_we_i(m_we),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb),
    .m_dat_o(a_m_dat), .m_ack_o(a_m_ack), .m_err_o(a_m_err), .m_rty_o(a_m_rty),
    .s_adr_o(a_s_adr), .s_dat_o(a_s_dat), .s_sel_o(a_s_sel), .s_we_o(a_s_we),
    .s_cyc_o(a_s_cyc), .s_stb_o(a_s_stb),
    .s_dat_i(s_dat), .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty)
  );

  wb_xbar_rr #(.NUM_MASTERS(NM), .NUM_SLAVES(NS), .SLAVE_ADDR(ADDRS),
               .SLAVE_MASK(MASKS), .TIMEOUT(0)) u_dut_nowd (
    .clk_i(clk), .rst_i(rst),
    .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel), .m_we_i(m_we),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb),
    .m_dat_o(b_m_dat), .m_ack_o(b_m_ack), .m_err_o(b_m_err), .m_rty_o(b_m_rty),
    .s_adr_o(b_s_adr), .s_dat_o(b_s_dat), .s_sel_o(b_s_sel), .s_we_o(b_s_we),
    .s_cyc_o(b_s_cyc), .s_stb_o(b_s_stb),
    .s_dat_i(s_dat), .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst   = 1'b1;
    m_adr = 64'h0;
    m_dat = 64'h0000_0002_0000_0001;
    m_sel = 8'hFF;
    m_we  = 2'b00;
    m_cyc = 2'b00;
    m_stb = 2'b00;
    s_dat = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'hDEAD_BEEF};
    s_ack = 4'b0000;
    s_err = 4'b0000;
    s_rty = 4'b0000;
    tick();
    tick();
    #2;
    check_eq("rst_s_cyc", {28'h0, a_s_cyc}, 32'h0);
    check_eq("rst_m_ack", {30'h0, a_m_ack}, 32'h0);
    check_eq("rst_m_err", {30'h0, a_m_err}, 32'h0);
    check_eq("rst_s_adr", a_s_adr, 32'h0);
    rst = 1'b0;

    // Single read through slave0 (slave3 also matches; lowest index wins).
    tick();
    m_adr = {32'h5000_0000, 32'h4000_0010};
    m_cyc = 2'b01;
    m_stb = 2'b01;
    #2;
    check_eq("rd_idle_s_cyc", {28'h0, a_s_cyc}, 32'h0);
    tick();
    #2;
    check_eq("rd_s_cyc", {28'h0, a_s_cyc}, 32'h1);
    check_eq("rd_s_stb", {28'h0, a_s_stb}, 32'h1);
    check_eq("rd_s_adr", a_s_adr, 32'h4000_0010);
    check_eq("rd_noack1", {30'h0, a_m_ack}, 32'h0);
    tick();
    #2;
    check_eq("rd_noack2", {30'h0, a_m_ack}, 32'h0);
    tick();
    s_ack = 4'b0001;
    #2;
    check_eq("rd_ack", {30'h0, a_m_ack}, 32'h1);
    check_eq("rd_dat", a_m_dat, 32'hDEAD_BEEF);
    check_eq("rd_err", {30'h0, a_m_err}, 32'h0);
    tick();
    s_ack = 4'b0000;
    m_cyc = 2'b00;
    m_stb = 2'b00;
    #2;
    check_eq("rd_drop_s_cyc", {28'h0, a_s_cyc}, 32'h0);
    tick();
    #2;
    check_eq("rd_idle_dat", a_m_dat, 32'h0);

    // Round robin: both masters request every opportunity, one beat each.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int r = 0; r < 4; r++) begin
      m_cyc = 2'b11;
      m_stb = 2'b11;
      s_ack = 4'b0000;
      #2;
      check_eq("rr_dead_s_cyc", {28'h0, a_s_cyc}, 32'h0);
      tick();
      s_ack = (r % 2 == 0) ? 4'b0001 : 4'b0010;
      #2;
      check_eq("rr_s_cyc", {28'h0, a_s_cyc}, (r % 2 == 0) ? 32'h1 : 32'h2);
      check_eq("rr_m_ack", {30'h0, a_m_ack}, (r % 2 == 0) ? 32'h1 : 32'h2);
      tick();
      m_cyc = (r % 2 == 0) ? 2'b10 : 2'b01;
      m_stb = m_cyc;
      s_ack = 4'b0000;
      #2;
      check_eq("rr_rel_m_ack", {30'h0, a_m_ack}, 32'h0);
      tick();
    end

    // m1 holds cyc across four strobes while m0 waits.
    m_cyc = 2'b10;
    m_stb = 2'b10;
    #2;
    check_eq("hold_idle", {28'h0, a_s_cyc}, 32'h0);
    tick();
    for (int b = 0; b < 4; b++) begin
      m_cyc = 2'b11;
      m_stb = 2'b11;
      s_ack = 4'b0010;
      #2;
      check_eq("hold_ack", {30'h0, a_m_ack}, 32'h2);
      check_eq("hold_s_cyc", {28'h0, a_s_cyc}, 32'h2);
      tick();
      m_stb = 2'b01;
      s_ack = 4'b0000;
      #2;
      check_eq("hold_gap_stb", {28'h0, a_s_stb}, 32'h0);
      check_eq("hold_gap_cyc", {28'h0, a_s_cyc}, 32'h2);
      tick();
    end
    m_cyc = 2'b01;
    m_stb = 2'b01;
    #2;
    check_eq("hold_rel", {28'h0, a_s_cyc}, 32'h0);
    tick();
    #2;
    check_eq("hold_dead", {28'h0, a_s_cyc}, 32'h0);
    tick();
    #2;
    check_eq("hold_m0_grant", {28'h0, a_s_cyc}, 32'h1);
    m_cyc = 2'b00;
    m_stb = 2'b00;
    tick();

    // Unmapped address: one internal error, one cycle after the strobe.
    m_adr = {32'h5000_0000, 32'h9000_0000};
    m_cyc = 2'b01;
    m_stb = 2'b01;
    tick();
    #2;
    check_eq("um_s_cyc", {28'h0, a_s_cyc}, 32'h0);
    check_eq("um_err_s1", {30'h0, a_m_err}, 32'h0);
    check_eq("um_dat", a_m_dat, 32'h0);
    tick();
    #2;
    check_eq("um_err_s2", {30'h0, a_m_err}, 32'h1);
    check_eq("um_s_cyc2", {28'h0, a_s_cyc}, 32'h0);
    tick();
    m_stb = 2'b00;
    #2;
    check_eq("um_err_s3", {30'h0, a_m_err}, 32'h0);
    tick();
    #2;
    check_eq("um_err_s4", {30'h0, a_m_err}, 32'h0);
    m_cyc = 2'b00;
    tick();

    // Watchdog: slave2 never acks in time; a late ack on the timeout cycle is dropped.
    m_adr = {32'h5000_0000, 32'h6000_0000};
    m_cyc = 2'b01;
    m_stb = 2'b01;
    tick();
    for (int c = 1; c <= 9; c++) begin
      s_ack = (c == 8) ? 4'b0100 : 4'b0000;
      #2;
      if (c == 8) begin
        check_eq("wd_to_s_cyc", {28'h0, a_s_cyc}, 32'h0);
        check_eq("wd_to_err", {30'h0, a_m_err}, 32'h1);
        check_eq("wd_to_ack", {30'h0, a_m_ack}, 32'h0);
      end else begin
        check_eq("wd_s_cyc", {28'h0, a_s_cyc}, 32'h4);
        check_eq("wd_err", {30'h0, a_m_err}, 32'h0);
      end
      check_eq("nowd_err", {30'h0, b_m_err}, 32'h0);
      check_eq("nowd_s_cyc", {28'h0, b_s_cyc}, 32'h4);
      tick();
    end
    s_ack = 4'b0000;
    m_cyc = 2'b00;
    m_stb = 2'b00;
    tick();

    // Reset during m1's owned cycle, then m0 wins first.
    m_adr = {32'h5000_0000, 32'h4000_0010};
    m_cyc = 2'b10;
    m_stb = 2'b10;
    tick();
    #2;
    check_eq("rstmid_own", {28'h0, a_s_cyc}, 32'h2);
    m_cyc = 2'b11;
    m_stb = 2'b11;
    s_ack = 4'b0010;
    rst = 1'b1;
    tick();
    #2;
    check_eq("rstmid_s_cyc", {28'h0, a_s_cyc}, 32'h0);
    check_eq("rstmid_m_ack", {30'h0, a_m_ack}, 32'h0);
    check_eq("rstmid_s_adr", a_s_adr, 32'h0);
    rst = 1'b0;
    tick();
    #2;
    check_eq("rstmid_m0_first", {28'h0, a_s_cyc}, 32'h1);
    check_eq("rstmid_m0_adr", a_s_adr, 32'h4000_0010);
    check_eq("rstmid_m0_noack", {30'h0, a_m_ack}, 32'h0);
    m_cyc = 2'b00;
    m_stb = 2'b00;
    s_ack = 4'b0000;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
